// File: rtl/disp_pkg.sv
// Shared constants, state encoding and round-robin helper for the display scan arbiter.
package disp_pkg;

  localparam int NREQ_MAX = 4;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] DP_MASK   = 8'h7F;

  typedef enum logic {IDLE, SHOW} state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Search last+1, last+2, ... (mod n); the last owner itself is the final
  // candidate unless skip_last is set.
  function automatic rr_pick_t rr_next(input logic [NREQ_MAX-1:0] req,
                                       input logic [1:0]          last,
                                       input logic [2:0]          n,
                                       input logic                skip_last);
    rr_pick_t   pick;
    logic [2:0] cand;
    pick = '0;
    for (int k = 1; k <= NREQ_MAX; k++) begin
      cand = {1'b0, last} + 3'(k);
      if (cand >= n) cand = cand - n;
      if (3'(k) <= n && !pick.found && !(skip_last && 3'(k) == n) && req[cand[1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment code; dp bit is always off here.
module hex7seg_dec
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan_arbiter.sv
// Round-robin owner arbitration with dwell time, per-frame snapshot and 4-digit scan.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero nibble.
module disp_scan_arbiter
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DWELL_FRAMES = 256,
  parameter int NREQ         = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*16-1:0] val,
  input  logic              lock,
  output logic [7:0]        Dis,
  output logic [3:0]        Cs,
  output logic [NREQ-1:0]   grant,
  output logic              frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int VW = NREQ_MAX * 16;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES - 1);
  localparam logic [1:0]    OWNER_RST = 2'(NREQ - 1);
  localparam logic [2:0]    NREQ_L    = 3'(NREQ);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          digit_q, digit_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [15:0]         snap_q, snap_d;
  logic [1:0]          owner_q, owner_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [7:0]          dis_q, dis_d;
  logic [3:0]          cs_q, cs_d;
  logic                tick, boundary, blank;
  logic [NREQ_MAX-1:0] req_ext;
  logic [VW-1:0]       val_ext;
  rr_pick_t            pick_any, pick_other;
  logic [3:0]          nib;
  logic [7:0]          seg;

  assign req_ext = NREQ_MAX'(req);
  assign val_ext = VW'(val);

  hex7seg_dec u_dec (.nib(nib), .seg(seg));

  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (digit_q == 2'd3);
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    digit_d  = tick ? digit_q + 2'd1 : digit_q;

    state_d = state_q;
    owner_d = owner_q;
    dwell_d = dwell_q;
    snap_d  = snap_q;

    // owner_q doubles as the round-robin pointer while idle
    pick_any   = rr_next(req_ext, owner_q, NREQ_L, 1'b0);
    pick_other = rr_next(req_ext, owner_q, NREQ_L, 1'b1);

    if (boundary) begin
      if (state_q == IDLE || !req_ext[owner_q]) begin
        if (pick_any.found) begin
          state_d = SHOW;
          owner_d = pick_any.idx;
          dwell_d = '0;
        end else begin
          state_d = IDLE;
        end
      end else if (dwell_q == DWELL_MAX && !lock && pick_other.found) begin
        owner_d = pick_other.idx;
        dwell_d = '0;
      end else if (dwell_q != DWELL_MAX) begin
        dwell_d = dwell_q + DW'(1);
      end
      if (state_d == SHOW) snap_d = val_ext[{owner_d, 4'b0000} +: 16];
    end

    grant_d = (state_d == SHOW) ? NREQ'(4'b0001 << owner_d) : '0;

    nib   = snap_d[{digit_d, 2'b00} +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (digit_d != 2'd0) && ((snap_d >> {digit_d, 2'b00}) == 16'h0000);
`endif

    dis_d = dis_q;
    cs_d  = cs_q;
    if (tick) begin
      if (state_d == SHOW) begin
        cs_d  = ~(4'b0001 << digit_d);
        dis_d = blank ? SEG_BLANK : seg;
        if (digit_d == 2'd3 && lock) dis_d = dis_d & DP_MASK;
      end else begin
        cs_d  = 4'hF;
        dis_d = SEG_BLANK;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      digit_q <= '0;
      dwell_q <= '0;
      snap_q  <= '0;
      owner_q <= OWNER_RST;
      grant_q <= '0;
      dis_q   <= SEG_BLANK;
      cs_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      dwell_q <= dwell_d;
      snap_q  <= snap_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      dis_q   <= dis_d;
      cs_q    <= cs_d;
    end
  end

  assign Dis        = dis_q;
  assign Cs         = cs_q;
  assign grant      = grant_q;
  assign frame_done = boundary;

endmodule
